// File: rtl/hmm_mem_arbiter.sv
// Three-way arbiter (host write, forward read, backtrace read) onto one HMM matrix memory port.
// Grant is same-cycle; memory command follows one cycle later; read data returns 3 cycles after grant. Requesters hold until granted.
module hmm_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_host,
  input  logic [ADDR_W-1:0] addr_host,
  input  logic [DATA_W-1:0] wdata_host,
  input  logic              req_fwd,
  input  logic [ADDR_W-1:0] addr_fwd,
  input  logic              lock_fwd,
  input  logic              req_bt,
  input  logic [ADDR_W-1:0] addr_bt,
  output logic              gnt_host,
  output logic              gnt_fwd,
  output logic              gnt_bt,
  output logic              rvalid_fwd,
  output logic              rvalid_bt,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [1:0] own1;  // read owner in the mem-command cycle: bit0 fwd, bit1 bt
  logic [1:0] own2;  // read owner in the mem-data cycle
  logic       host_force;

  always_comb begin
    gnt_host   = 1'b0;
    gnt_fwd    = 1'b0;
    gnt_bt     = 1'b0;
    host_force = (state == ST_ARB) && req_host && (wait_cnt == WAIT_LIM);
    if (reset) begin
      case (state)
        ST_ARB: begin
          if (host_force)   gnt_host = 1'b1;
          else if (req_fwd) gnt_fwd  = 1'b1;
          else if (req_bt)  gnt_bt   = 1'b1;
          else if (req_host) gnt_host = 1'b1;
        end
        ST_LOCK: begin
          // Dropping lock_fwd ends the burst; that cycle grants nobody.
          if (lock_fwd && req_fwd) gnt_fwd = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_ARB;
      wait_cnt   <= '0;
      own1       <= '0;
      own2       <= '0;
      rvalid_fwd <= 1'b0;
      rvalid_bt  <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_ARB:  if (gnt_fwd && lock_fwd) state <= ST_LOCK;
        ST_LOCK: if (!lock_fwd)           state <= ST_ARB;
      endcase

      if (!req_host || gnt_host)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;

      mem_en <= gnt_host | gnt_fwd | gnt_bt;
      mem_we <= gnt_host;
      if (gnt_host) begin
        mem_addr  <= addr_host;
        mem_wdata <= wdata_host;
      end else if (gnt_fwd) begin
        mem_addr  <= addr_fwd;
      end else if (gnt_bt) begin
        mem_addr  <= addr_bt;
      end

      own1       <= {gnt_bt, gnt_fwd};
      own2       <= own1;
      rvalid_fwd <= own2[0];
      rvalid_bt  <= own2[1];
      if (|own2) rdata <= mem_rdata;
    end
  end

  assign busy = (state == ST_LOCK) || (|own1) || (|own2);

endmodule
